// File: rtl/hilo_reg_pkg.sv
// rtl/hilo_reg_pkg.sv - shared defines and the merged HI/LO write type
package hilo_reg_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   typedef logic [31:0] RegBus;

   typedef struct packed {
      logic  valid;
      RegBus hi;
      RegBus lo;
   } hilo_wr_t;

   // An exception in the older slot also kills the younger slot's write.
   function automatic hilo_wr_t merge_slots(
      input logic  s1_whilo, input logic s1_exc, input RegBus s1_hi, input RegBus s1_lo,
      input logic  s2_whilo, input logic s2_exc, input RegBus s2_hi, input RegBus s2_lo);
      hilo_wr_t m;
      logic     eff1;
      logic     eff2;
      eff1    = s1_whilo & ~s1_exc;
      eff2    = s2_whilo & ~s2_exc & ~s1_exc;
      m.valid = (eff1 | eff2) ? WriteEnable : WriteDisable;
      if (eff2) begin
         m.hi = s2_hi;
         m.lo = s2_lo;
      end else if (eff1) begin
         m.hi = s1_hi;
         m.lo = s1_lo;
      end else begin
         m.hi = ZeroWord;
         m.lo = ZeroWord;
      end
      return m;
   endfunction

endpackage

// File: rtl/hilo_reg_if.sv
// rtl/hilo_reg_if.sv - pipeline-side HI/LO bundle with master/slave views
interface hilo_reg_if;
   import hilo_reg_pkg::*;

   logic  stall_i;
   logic  flush_i;
   logic  s1_whilo_i;
   RegBus s1_hi_i;
   RegBus s1_lo_i;
   logic  s2_whilo_i;
   RegBus s2_hi_i;
   RegBus s2_lo_i;
   logic  s1_exc_i;
   logic  s2_exc_i;
   RegBus hi_o;
   RegBus lo_o;
   RegBus hi_arch_o;
   RegBus lo_arch_o;
   logic  pending_o;

   modport master (
      output stall_i, flush_i,
      output s1_whilo_i, s1_hi_i, s1_lo_i,
      output s2_whilo_i, s2_hi_i, s2_lo_i,
      output s1_exc_i, s2_exc_i,
      input  hi_o, lo_o, hi_arch_o, lo_arch_o, pending_o
   );

   modport slave (
      input  stall_i, flush_i,
      input  s1_whilo_i, s1_hi_i, s1_lo_i,
      input  s2_whilo_i, s2_hi_i, s2_lo_i,
      input  s1_exc_i, s2_exc_i,
      output hi_o, lo_o, hi_arch_o, lo_arch_o, pending_o
   );

endinterface

// File: rtl/hilo_stage.sv
// rtl/hilo_stage.sv - one valid/hi/lo pipeline latch with load, hold and clear
module hilo_stage
   import hilo_reg_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     hold,
   input  logic     clear,
   input  hilo_wr_t d,
   output hilo_wr_t q
);

   // clear only drops the valid bit; stale data behind it is never selected
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         q.valid <= WriteDisable;
         q.hi    <= ZeroWord;
         q.lo    <= ZeroWord;
      end else if (clear) begin
         q.valid <= WriteDisable;
      end else if (load && !hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - dual-issue HI/LO register with MEM/WB latches; HILO_BYPASS_EN enables forwarding
module hilo_reg
   import hilo_reg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   hilo_reg_if.slave  bus
);

   hilo_wr_t ex_wr;
   hilo_wr_t mem_q;
   hilo_wr_t wb_q;
   RegBus    hi_arch;
   RegBus    lo_arch;

   assign ex_wr = merge_slots(bus.s1_whilo_i, bus.s1_exc_i, bus.s1_hi_i, bus.s1_lo_i,
                              bus.s2_whilo_i, bus.s2_exc_i, bus.s2_hi_i, bus.s2_lo_i);

   hilo_stage u_mem (
      .clk   (clk),
      .rst   (rst),
      .load  (1'b1),
      .hold  (bus.stall_i),
      .clear (bus.flush_i),
      .d     (ex_wr),
      .q     (mem_q)
   );

   // a stall or flush pushes a bubble into WB while MEM holds or empties
   hilo_stage u_wb (
      .clk   (clk),
      .rst   (rst),
      .load  (1'b1),
      .hold  (1'b0),
      .clear (bus.stall_i | bus.flush_i),
      .d     (mem_q),
      .q     (wb_q)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         hi_arch <= ZeroWord;
         lo_arch <= ZeroWord;
      end else if (wb_q.valid) begin
         hi_arch <= wb_q.hi;
         lo_arch <= wb_q.lo;
      end
   end

`ifdef HILO_BYPASS_EN
   always_comb begin
      bus.hi_o = hi_arch;
      bus.lo_o = lo_arch;
      if (mem_q.valid) begin
         bus.hi_o = mem_q.hi;
         bus.lo_o = mem_q.lo;
      end else if (wb_q.valid) begin
         bus.hi_o = wb_q.hi;
         bus.lo_o = wb_q.lo;
      end
   end
`else
   assign bus.hi_o = hi_arch;
   assign bus.lo_o = lo_arch;
`endif

   assign bus.hi_arch_o = hi_arch;
   assign bus.lo_arch_o = lo_arch;
   assign bus.pending_o = mem_q.valid | wb_q.valid;

endmodule

// File: tb/tb_hilo_reg.sv
// tb/tb_hilo_reg.sv - directed self-checking bench for hilo_reg (bypass on or off)
module tb_hilo_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   hilo_reg_if bus ();

   hilo_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fwd(input logic [31:0] bypassed, input logic [31:0] arch);
`ifdef HILO_BYPASS_EN
      return bypassed;
`else
      return arch;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.s1_whilo_i = 1'b0; bus.s1_hi_i = 32'h0; bus.s1_lo_i = 32'h0; bus.s1_exc_i = 1'b0;
      bus.s2_whilo_i = 1'b0; bus.s2_hi_i = 32'h0; bus.s2_lo_i = 32'h0; bus.s2_exc_i = 1'b0;
   endtask

   task automatic wr1(input logic [31:0] hi, input logic [31:0] lo);
      idle();
      bus.s1_whilo_i = 1'b1; bus.s1_hi_i = hi; bus.s1_lo_i = lo;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b0;
      tick();
      do_reset();

      chk("reset hi_o",      bus.hi_o,      32'h0);
      chk("reset lo_o",      bus.lo_o,      32'h0);
      chk("reset hi_arch",   bus.hi_arch_o, 32'h0);
      chk("reset lo_arch",   bus.lo_arch_o, 32'h0);
      chk("reset pending",   32'(bus.pending_o), 32'h0);

      // single s1 write: forward at +1, commit at +3
      wr1(32'h11, 32'h22);
      tick(); idle();
      chk("w1 +1 hi_o",      bus.hi_o,      fwd(32'h11, 32'h0));
      chk("w1 +1 lo_o",      bus.lo_o,      fwd(32'h22, 32'h0));
      chk("w1 +1 pending",   32'(bus.pending_o), 32'h1);
      chk("w1 +1 hi_arch",   bus.hi_arch_o, 32'h0);
      tick();
      chk("w1 +2 hi_o",      bus.hi_o,      fwd(32'h11, 32'h0));
      chk("w1 +2 pending",   32'(bus.pending_o), 32'h1);
      chk("w1 +2 hi_arch",   bus.hi_arch_o, 32'h0);
      tick();
      chk("w1 +3 hi_arch",   bus.hi_arch_o, 32'h11);
      chk("w1 +3 lo_arch",   bus.lo_arch_o, 32'h22);
      chk("w1 +3 hi_o",      bus.hi_o,      32'h11);
      chk("w1 +3 pending",   32'(bus.pending_o), 32'h0);

      // both slots write: younger slot wins
      wr1(32'hA, 32'h1);
      bus.s2_whilo_i = 1'b1; bus.s2_hi_i = 32'hB; bus.s2_lo_i = 32'h2;
      tick(); idle();
      chk("dual +1 hi_o",    bus.hi_o,      fwd(32'hB, 32'h11));
      tick(); tick();
      chk("dual hi_arch",    bus.hi_arch_o, 32'hB);
      chk("dual lo_arch",    bus.lo_arch_o, 32'h2);

      // s1 exception kills both slots
      wr1(32'hDEAD, 32'hBEEF);
      bus.s1_exc_i = 1'b1;
      bus.s2_whilo_i = 1'b1; bus.s2_hi_i = 32'hCAFE; bus.s2_lo_i = 32'hF00D;
      tick(); idle();
      chk("exc1 pending",    32'(bus.pending_o), 32'h0);
      chk("exc1 hi_o",       bus.hi_o,      32'hB);
      tick(); tick();
      chk("exc1 hi_arch",    bus.hi_arch_o, 32'hB);
      chk("exc1 lo_arch",    bus.lo_arch_o, 32'h2);

      // s2 exception only drops the younger write
      wr1(32'h33, 32'h44);
      bus.s2_whilo_i = 1'b1; bus.s2_exc_i = 1'b1; bus.s2_hi_i = 32'h55; bus.s2_lo_i = 32'h66;
      tick(); idle();
      tick(); tick();
      chk("exc2 hi_arch",    bus.hi_arch_o, 32'h33);
      chk("exc2 lo_arch",    bus.lo_arch_o, 32'h44);

      // flush discards MEM, HI keeps its old value
      do_reset();
      wr1(32'h5, 32'h6);
      tick(); idle();
      chk("flush pre hi_o",  bus.hi_o,      fwd(32'h5, 32'h0));
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("flush pending",   32'(bus.pending_o), 32'h0);
      chk("flush hi_o",      bus.hi_o,      32'h0);
      tick(); tick();
      chk("flush hi_arch",   bus.hi_arch_o, 32'h0);

      // a write already in WB at the flush still commits
      wr1(32'h9, 32'h0);
      tick();
      wr1(32'h5, 32'h0);
      tick(); idle();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("wbflush hi_arch", bus.hi_arch_o, 32'h9);
      chk("wbflush pending", 32'(bus.pending_o), 32'h0);
      tick();
      chk("wbflush hold",    bus.hi_arch_o, 32'h9);

      // two-cycle stall with MEM holding 0x7
      wr1(32'h7, 32'h8);
      tick(); idle();
      bus.stall_i = 1'b1;
      chk("stall0 hi_o",     bus.hi_o,      fwd(32'h7, 32'h9));
      tick();
      chk("stall1 hi_o",     bus.hi_o,      fwd(32'h7, 32'h9));
      chk("stall1 pending",  32'(bus.pending_o), 32'h1);
      tick();
      chk("stall2 hi_o",     bus.hi_o,      fwd(32'h7, 32'h9));
      chk("stall2 hi_arch",  bus.hi_arch_o, 32'h9);
      bus.stall_i = 1'b0;
      tick();
      chk("stall3 hi_o",     bus.hi_o,      fwd(32'h7, 32'h9));
      chk("stall3 hi_arch",  bus.hi_arch_o, 32'h9);
      tick();
      chk("stall4 hi_arch",  bus.hi_arch_o, 32'h7);
      chk("stall4 lo_arch",  bus.lo_arch_o, 32'h8);
      chk("stall4 pending",  32'(bus.pending_o), 32'h0);

      // reset with MEM and WB both valid drops everything
      wr1(32'h21, 32'h22);
      tick();
      wr1(32'h31, 32'h32);
      tick(); idle();
      chk("prerst pending",  32'(bus.pending_o), 32'h1);
      do_reset();
      chk("rst hi_o",        bus.hi_o,      32'h0);
      chk("rst lo_o",        bus.lo_o,      32'h0);
      chk("rst hi_arch",     bus.hi_arch_o, 32'h0);
      chk("rst lo_arch",     bus.lo_arch_o, 32'h0);
      chk("rst pending",     32'(bus.pending_o), 32'h0);
      tick(); tick();
      chk("rst drop arch",   bus.hi_arch_o, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
